// File: rtl/data_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_responder_pkg
//   Constants and helpers shared by the data SRAM responder:
//   - MMIO window default and register offsets
//   - mmio_reg_e: decoded MMIO register select
//   - byte_merge(): byte-lane write merge used by the RAM, NUM and TIMER
//   - decode_reg(): map an MMIO offset to a register select
// -----------------------------------------------------------------------------
package data_sram_responder_pkg;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'h1faf;

    localparam logic [15:0] LED_OFF   = 16'hF000;
    localparam logic [15:0] NUM_OFF   = 16'hF010;
    localparam logic [15:0] SW_OFF    = 16'hF020;
    localparam logic [15:0] TIMER_OFF = 16'hE000;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_NUM,
        REG_SW,
        REG_TIMER
    } mmio_reg_e;

    // Replace the bytes of old_val whose write-enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

    function automatic mmio_reg_e decode_reg(input logic [15:0] offset);
        mmio_reg_e sel;
        case (offset)
            LED_OFF:   sel = REG_LED;
            NUM_OFF:   sel = REG_NUM;
            SW_OFF:    sel = REG_SW;
            TIMER_OFF: sel = REG_TIMER;
            default:   sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// -----------------------------------------------------------------------------
// data_sram_responder_if
//   CPU data SRAM bus between the core (master) and the responder (slave).
//   en    : access enable
//   wen   : byte write enables (0000 with en=1 is a read)
//   addr  : byte address
//   wdata : write data, byte lane i = bits 8i+7:8i
//   rdata : read data, valid the cycle after a read
// -----------------------------------------------------------------------------
interface data_sram_responder_if;

    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output en,
        output wen,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  en,
        input  wen,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/data_sram_responder_bram.sv
// -----------------------------------------------------------------------------
// dsram_bram
//   Single-port, word-addressed synchronous RAM with byte write enables.
//   Written so a vendor block RAM can be dropped in unchanged.
//   clk   : clock
//   en    : access enable
//   wen   : byte write enables; 0000 with en=1 reads
//   addr  : word address
//   wdata : write data
//   rdata : read data register, updated only on reads, holds otherwise
// -----------------------------------------------------------------------------
module dsram_bram
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // NOTE: memory and its output register have no reset so this maps onto
    // block RAM; state updates use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wen != 4'b0000) begin
                mem[addr] <= byte_merge(mem[addr], wdata, wen);
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//   Responder end of the CPU data SRAM interface. Decodes each access to
//   either the word-addressed RAM or the MMIO window (addr[31:16] == MMIO_HI)
//   and returns read data one cycle after the request.
//
//   Ports:
//     clk     : core clock, rising edge
//     resetn  : asynchronous active-low reset
//     bus     : data SRAM bus (slave modport)
//     sw_in   : asynchronous board switches
//     led_out : LED register
//     num_out : seven-segment display value
//
//   MMIO registers (offset = addr[15:0]):
//     0xF000 LED    16 bit, lanes 0-1 writable
//     0xF010 NUM    32 bit, byte writable
//     0xF020 SWITCH read-only, synchronized sw_in
//     0xE000 TIMER  free-running counter, byte writable
//
//   Build option: define DSRAM_TIMER_EN to include the TIMER register;
//   without it 0xE000 reads 0 and ignores writes.
// -----------------------------------------------------------------------------
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT,
    parameter int unsigned SW_W    = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_sram_responder_if.slave bus,
    input  logic [SW_W-1:0]      sw_in,
    output logic [15:0]          led_out,
    output logic [31:0]          num_out
);

    logic            mmio_sel;
    logic            rd_req;
    logic            wr_req;
    mmio_reg_e       reg_sel;
    logic [31:0]     led_merged;
    logic [31:0]     timer_val;
    logic [31:0]     mmio_rd_val;
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;
    logic            mmio_sel_q;
    logic [31:0]     mmio_rdata_q;
    logic [31:0]     ram_rdata;
    logic            ram_en;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign mmio_sel = (bus.addr[31:16] == MMIO_HI);
    assign rd_req   = bus.en && (bus.wen == 4'b0000);
    assign wr_req   = bus.en && (bus.wen != 4'b0000);
    assign reg_sel  = mmio_sel ? decode_reg(bus.addr[15:0]) : REG_NONE;

    // ------------------------------------------------------------------
    // RAM: gated off while in reset so an interrupted access cannot land
    // ------------------------------------------------------------------
    assign ram_en = bus.en && !mmio_sel && resetn;

    dsram_bram #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .en    (ram_en),
        .wen   (bus.wen),
        .addr  (bus.addr[ADDR_W+1:2]),
        .wdata (bus.wdata),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // LED / NUM registers; LED only honours lanes 0-1
    // ------------------------------------------------------------------
    assign led_merged = byte_merge({16'h0000, led_out}, bus.wdata,
                                   {2'b00, bus.wen[1:0]});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_out <= '0;
            num_out <= '0;
        end else if (wr_req) begin
            if (reg_sel == REG_LED) begin
                led_out <= led_merged[15:0];
            end
            if (reg_sel == REG_NUM) begin
                num_out <= byte_merge(num_out, bus.wdata, bus.wen);
            end
        end
    end

    // ------------------------------------------------------------------
    // Switch synchronizer (two flops, sw_in is asynchronous)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Timer: a write overrides the increment only in the enabled lanes
    // ------------------------------------------------------------------
`ifdef DSRAM_TIMER_EN
    logic [31:0] timer_q;
    logic [31:0] timer_inc;

    assign timer_inc = timer_q + 32'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
        end else if (wr_req && (reg_sel == REG_TIMER)) begin
            timer_q <= byte_merge(timer_inc, bus.wdata, bus.wen);
        end else begin
            timer_q <= timer_inc;
        end
    end

    assign timer_val = timer_q;
`else
    assign timer_val = '0;
`endif

    // ------------------------------------------------------------------
    // MMIO read mux
    // ------------------------------------------------------------------
    // NOTE: default assignment first so every path drives the output and no
    // latch is inferred.
    always_comb begin
        mmio_rd_val = '0;
        case (reg_sel)
            REG_LED:   mmio_rd_val = {16'h0000, led_out};
            REG_NUM:   mmio_rd_val = num_out;
            REG_SW:    mmio_rd_val = 32'(sw_sync);
            REG_TIMER: mmio_rd_val = timer_val;
            default:   mmio_rd_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Read return. The RAM holds its own output register, so only the
    // source select and the MMIO value are captured here. Both update on
    // reads only, which makes rdata hold across write and idle cycles.
    // mmio_sel_q resets to 1 so rdata comes out of reset as mmio_rdata_q = 0
    // without needing a reset on the RAM output.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mmio_sel_q   <= 1'b1;
            mmio_rdata_q <= '0;
        end else if (rd_req) begin
            mmio_sel_q   <= mmio_sel;
            mmio_rdata_q <= mmio_rd_val;
        end
    end

    assign bus.rdata = mmio_sel_q ? mmio_rdata_q : ram_rdata;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.addr[1:0], led_merged[31:16]};

endmodule
